ccff_chain_loader: RTL and testbench
====================================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 15, giving the number of configuration flops in the target ccff chain (valid range 1..4095).
REQ-002 The block SHALL have parameter CNT_W, default 12, giving the bit-counter width; CHAIN_LEN SHALL NOT exceed 2^CNT_W-1.
REQ-003 The block SHALL have port prog_clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port prog_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to begin loading the chain.
REQ-006 The block SHALL have port cfg_data, input, 8 bits: a bitstream byte; bit 7 is shifted first.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: cfg_data is valid.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-009 The block SHALL have port ccff_head, output, 1 bit: serial data driven into the chain head.
REQ-010 The block SHALL have port ccff_shift_en, output, 1 bit: clock-gate enable for the chain's prog_clk; the chain advances one position per cycle while it is high.
REQ-011 The block SHALL have port ccff_tail, input, 1 bit: the chain tail, sampled for readback.
REQ-012 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: the last load completed.
REQ-014 The block SHALL have port rb_byte, output, 8 bits: the last 8 tail bits captured, newest in bit 0.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, SHIFT and DONE, and all outputs SHALL be derived from registers only.
REQ-016 In IDLE or DONE, start=1 SHALL move the FSM to FETCH, clear bit_cnt to 0, clear done and clear rb_byte.
REQ-017 start SHALL be ignored while the FSM is in FETCH or SHIFT.
REQ-018 cfg_ready SHALL be 1 only in FETCH.
REQ-019 When cfg_valid&cfg_ready, the byte SHALL be loaded into an 8-bit shift register, a 4-bit byte_cnt SHALL be set to 0, and the FSM SHALL move to SHIFT on the next edge.
REQ-020 While cfg_valid=0 in FETCH, the FSM SHALL stay in FETCH with ccff_shift_en=0 and the chain held.
REQ-021 In SHIFT, each cycle ccff_shift_en SHALL be 1 and ccff_head SHALL equal sreg[7]; at the edge, sreg SHALL shift left with a 0 fill, bit_cnt and byte_cnt SHALL increment, and ccff_tail SHALL shift into rb_byte[0].
REQ-022 SHIFT SHALL exit when bit_cnt+1==CHAIN_LEN, going to DONE.
REQ-023 Otherwise, SHIFT SHALL exit when byte_cnt==7, going to FETCH.
REQ-024 For a final partial byte, the low 8-(CHAIN_LEN mod 8) bits SHALL be ignored and never shifted.
REQ-025 ccff_shift_en SHALL be high for exactly CHAIN_LEN cycles per load.
REQ-026 Outside SHIFT, ccff_head SHALL be 0 and ccff_shift_en SHALL be 0.
REQ-027 Throughput SHALL be 1 byte per 9 cycles at minimum: 1 FETCH cycle plus 8 SHIFT cycles.
REQ-028 Latency from start to the first ccff_shift_en SHALL be 2 cycles when cfg_valid is already high.
REQ-029 busy SHALL be 1 in FETCH and SHIFT.
REQ-030 In DONE, done SHALL be 1 and held until the next start or reset.
REQ-031 A start coincident with entry into DONE SHALL be ignored, because the FSM is still in SHIFT on that cycle.
REQ-032 bit_cnt SHALL never wrap; its CNT_W width guarantees this.

Reset
REQ-033 Asserting prog_reset SHALL immediately force IDLE and clear all registers: sreg, bit_cnt, byte_cnt and rb_byte to 0; cfg_ready, ccff_head, ccff_shift_en, busy and done to 0.
REQ-034 A reset during SHIFT SHALL drop ccff_shift_en the same instant, leaving the chain partially loaded; no recovery is attempted and the next start reloads from bit 0.
REQ-035 Deassertion of prog_reset SHALL take effect at the next prog_clk edge.

Verification
REQ-036 The bench SHALL cover a nominal load: CHAIN_LEN=15, start, bytes 0xA5 then 0xC3 with cfg_valid held -> ccff_head over the 15 enable cycles is 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1; done=1; busy=0; total 17 cycles from start to DONE.
REQ-037 The bench SHALL cover a stalled source: cfg_valid low for 5 cycles between the two bytes -> FETCH is held, ccff_shift_en=0 for those 5 cycles, and the same 15-bit sequence and enable count result.
REQ-038 The bench SHALL cover readback: preload a chain model with 0x7FFF, then load all-zero bytes -> rb_byte=0xFF after the load, and after a second identical load rb_byte=0x00.
REQ-039 The bench SHALL cover reset mid-load: assert prog_reset after the 10th enable cycle -> outputs are 0 asynchronously; a following start and full load gives exactly 15 enable cycles and done=1.
REQ-040 The bench SHALL cover ignored start: pulse start during SHIFT -> no restart, bit_cnt is unaffected, and the load completes normally.
REQ-041 The bench SHALL cover the edge case CHAIN_LEN=8 with one byte 0x81 -> 8 enable cycles, ccff_head sequence 1,0,0,0,0,0,0,1, then DONE with no second FETCH.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams bitstream bytes MSB-first into a ccff chain, gating its clock
// and capturing the chain tail for readback.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 15,
   parameter int CNT_W     = 12
) (
   input  logic       prog_clk,
   input  logic       prog_reset,
   input  logic       start,
   input  logic [7:0] cfg_data,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   output logic       ccff_head,
   output logic       ccff_shift_en,
   input  logic       ccff_tail,
   output logic       busy,
   output logic       done,
   output logic [7:0] rb_byte
);
   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
   state_t state, state_nx;
   logic [7:0] sreg, sreg_nx, rb_nx;
   logic [CNT_W-1:0] bit_cnt, bit_nx;
   logic [3:0] byte_cnt, byte_nx;
   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         state    <= IDLE;
         sreg     <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         rb_byte  <= '0;
      end else begin
         state    <= state_nx;
         sreg     <= sreg_nx;
         bit_cnt  <= bit_nx;
         byte_cnt <= byte_nx;
         rb_byte  <= rb_nx;
      end
   end
   always_comb begin
      state_nx = state;
      sreg_nx  = sreg;
      bit_nx   = bit_cnt;
      byte_nx  = byte_cnt;
      rb_nx    = rb_byte;
      case (state)
         IDLE, DONE: if (start) begin
            state_nx = FETCH;
            bit_nx   = '0;
            rb_nx    = '0;
         end
         FETCH: if (cfg_valid) begin
            sreg_nx  = cfg_data;
            byte_nx  = '0;
            state_nx = SHIFT;
         end
         SHIFT: begin
            sreg_nx  = {sreg[6:0], 1'b0};
            bit_nx   = bit_cnt + 1'b1;
            byte_nx  = byte_cnt + 1'b1;
            rb_nx    = {rb_byte[6:0], ccff_tail};
            // chain end wins over byte end, so a trailing partial byte is dropped
            state_nx = (bit_cnt == LAST) ? DONE : (byte_cnt == 4'd7) ? FETCH : SHIFT;
         end
         default: state_nx = IDLE;
      endcase
   end
   assign cfg_ready     = state == FETCH;
   assign ccff_shift_en = state == SHIFT;
   assign ccff_head     = ccff_shift_en & sreg[7];
   assign busy          = cfg_ready | ccff_shift_en;
   assign done          = state == DONE;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed checks of chain loading, stalls, readback, reset and
// a single-byte chain.
module tb_ccff_chain_loader;
   logic clk = 0, rst = 1, start = 0, start8 = 0, cfg_valid = 0, preload = 0;
   logic [7:0] cfg_data = 0;
   logic ready, head, en, busy, done, tail;
   logic [7:0] rb;
   logic ready8, head8, en8, busy8, done8;
   logic [7:0] rb8;
   logic tail8 = 0;
   logic [14:0] chain = '0;
   logic [31:0] seq = 0, seq8 = 0;
   int ne = 0, nb = 0, ne8 = 0, nf8 = 0;
   int n_assert = 0, n_fail = 0;
   always #5 clk = ~clk;
   ccff_chain_loader dut (
      .prog_clk(clk), .prog_reset(rst), .start(start), .cfg_data(cfg_data),
      .cfg_valid(cfg_valid), .cfg_ready(ready), .ccff_head(head), .ccff_shift_en(en),
      .ccff_tail(tail), .busy(busy), .done(done), .rb_byte(rb)
   );
   ccff_chain_loader #(.CHAIN_LEN(8)) dut8 (
      .prog_clk(clk), .prog_reset(rst), .start(start8), .cfg_data(cfg_data),
      .cfg_valid(cfg_valid), .cfg_ready(ready8), .ccff_head(head8), .ccff_shift_en(en8),
      .ccff_tail(tail8), .busy(busy8), .done(done8), .rb_byte(rb8)
   );
   // 15-flop chain model clocked only while the loader enables it
   assign tail = chain[14];
   always @(posedge clk) chain <= preload ? 15'h7FFF : en ? {chain[13:0], head} : chain;
   always @(negedge clk) begin
      if (en) begin
         ne  <= ne + 1;
         seq <= {seq[30:0], head};
      end
      if (busy) nb <= nb + 1;
      if (en8) begin
         ne8  <= ne8 + 1;
         seq8 <= {seq8[30:0], head8};
      end
      if (ready8) nf8 <= nf8 + 1;
   end
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask
   task automatic load(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [14:0] exp_seq, input int stall, input bit poke);
      int e0, b0, e1;
      e0 = ne;
      b0 = nb;
      cfg_data = a;
      cfg_valid = 1;
      start = 1;
      step(1);
      start = 0;
      check({tag, " fetch"}, {ready, en, busy, rb}, {1'b1, 1'b0, 1'b1, 8'h00});
      step(1);
      cfg_data = b;
      check({tag, " first en"}, {en, ready}, 2'b10);
      if (stall > 0) begin
         cfg_valid = 0;
         for (int i = 0; i < 20 && !ready; i++) step(1);
         e1 = ne;
         step(stall);
         check({tag, " stall en"}, ne - e1, 0);
         check({tag, " stall ready"}, ready, 1);
         cfg_valid = 1;
      end
      if (poke) begin
         step(3);
         start = 1;
         step(1);
         start = 0;
         check({tag, " poke"}, {en, ready}, 2'b10);
      end
      for (int i = 0; i < 100 && !done; i++) step(1);
      check({tag, " done"}, {done, busy, en, ready}, 4'b1000);
      check({tag, " en cycles"}, ne - e0, 15);
      check({tag, " busy cycles"}, nb - b0, 17 + stall);
      check({tag, " head seq"}, seq[14:0], exp_seq);
      step(2);
      check({tag, " done held"}, done, 1);
   endtask
   initial begin
      int e0, f0;
      #1;
      check("reset outs", {ready, head, en, busy, done, rb}, 0);
      step(2);
      rst = 0;
      step(1);
      check("idle outs", {ready, head, en, busy, done, rb}, 0);
      // A5 then the top 7 bits of C3
      load("nominal", 8'hA5, 8'hC3, 15'h52E1, 0, 0);
      load("stall", 8'hA5, 8'hC3, 15'h52E1, 5, 0);
      load("poke", 8'hA5, 8'hC3, 15'h52E1, 0, 1);
      preload = 1;
      step(1);
      preload = 0;
      load("rb1", 8'h00, 8'h00, 15'h0000, 0, 0);
      check("rb1 byte", rb, 8'hFF);
      load("rb2", 8'h00, 8'h00, 15'h0000, 0, 0);
      check("rb2 byte", rb, 8'h00);
      cfg_data = 8'hA5;
      cfg_valid = 1;
      start = 1;
      step(1);
      start = 0;
      e0 = ne;
      step(1);
      cfg_data = 8'hC3;
      for (int i = 0; i < 40 && ne - e0 < 10; i++) step(1);
      check("pre-reset en count", ne - e0, 10);
      @(posedge clk);
      #1;
      rst = 1;
      #1;
      check("mid-load reset outs", {ready, head, en, busy, done, rb}, 0);
      step(2);
      rst = 0;
      step(1);
      check("post-reset idle", {ready, en, busy, done}, 0);
      load("after reset", 8'hA5, 8'hC3, 15'h52E1, 0, 0);
      f0 = nf8;
      e0 = ne8;
      cfg_data = 8'h81;
      cfg_valid = 1;
      start8 = 1;
      step(1);
      start8 = 0;
      for (int i = 0; i < 40 && !done8; i++) step(1);
      check("len8 done", {done8, busy8, en8, ready8}, 4'b1000);
      check("len8 en cycles", ne8 - e0, 8);
      check("len8 head seq", seq8[7:0], 8'h81);
      check("len8 fetch cycles", nf8 - f0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
